// File: rtl/lfsr_prng.sv
// lfsr_prng: Fibonacci LFSR pseudo-random word generator with valid/ready output.
//
// Each output word is produced after STEPS_PER_OUT shifts of the LFSR. This keeps
// consecutive words decorrelated. The state can be reseeded at runtime. A held
// word stays stable under backpressure until the consumer takes it.
//
// Optional feature macro: LFSR_PRNG_ZERO_GUARD_EN
//   When defined, an all-zero seed is replaced by INIT_VALUE and out_lockup
//   pulses for one cycle. When undefined, a zero seed is loaded as-is and
//   out_lockup is tied low.
//
// Parameters:
//   DATA_WIDTH    - LFSR and output word width (2..64)
//   POLYNOM       - tap mask; bit i set feeds state bit i into the feedback XOR
//   INIT_VALUE    - non-zero state after reset (and zero-seed replacement)
//   STEPS_PER_OUT - LFSR shifts per output word (1..255)
//
// Ports:
//   in_clk       - clock, rising edge
//   in_rst       - asynchronous active-high reset
//   in_en        - request generation (sampled in IDLE and at a handshake)
//   in_load      - load in_seed into the LFSR state (highest priority)
//   in_seed      - seed value
//   in_ready     - consumer accepts out_rnd_data while out_valid is high
//   out_rnd_data - registered generated word
//   out_valid    - out_rnd_data holds an unconsumed word
//   out_lockup   - one-cycle pulse after a zero seed was replaced

module lfsr_prng #(
  parameter int unsigned           DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] POLYNOM       = 16'hB400,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = 16'hAAAA,
  parameter int unsigned           STEPS_PER_OUT = 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_en,
  input  logic                  in_load,
  input  logic [DATA_WIDTH-1:0] in_seed,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_rnd_data,
  output logic                  out_valid,
  output logic                  out_lockup
);

  localparam int unsigned   CntW    = $clog2(STEPS_PER_OUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STEPS_PER_OUT);

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StValid
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] lfsr_shift;
  logic [CntW-1:0]       cnt_inc;
  logic [DATA_WIDTH-1:0] load_value;

  // One Fibonacci shift: feedback is the parity of the tapped bits, entering at bit 0.
  assign lfsr_shift = {lfsr_q[DATA_WIDTH-2:0], ^(lfsr_q & POLYNOM)};
  assign cnt_inc    = cnt_q + 1'b1;

`ifdef LFSR_PRNG_ZERO_GUARD_EN
  logic seed_zero;
  logic lockup_q;

  assign seed_zero  = (in_seed == '0);
  // An all-zero state would be a fixed point of the LFSR, so never let it in.
  assign load_value = seed_zero ? INIT_VALUE : in_seed;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= in_load & seed_zero;
    end
  end

  assign out_lockup = lockup_q;
`else
  assign load_value = in_seed;
  assign out_lockup = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (in_load) begin
      // Reseed wins over everything; a pending word is dropped, but the data
      // register keeps its last value.
      lfsr_d  = load_value;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_en) begin
            cnt_d   = '0;
            state_d = StStep;
          end
        end
        StStep: begin
          lfsr_d = lfsr_shift;
          cnt_d  = cnt_inc;
          if (cnt_inc == CntLast) begin
            data_d  = lfsr_shift;
            valid_d = 1'b1;
            state_d = StValid;
          end
        end
        StValid: begin
          // Handshake cycle does not shift; it only decides whether to continue.
          if (in_ready) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = in_en ? StStep : StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= StIdle;
      lfsr_q  <= INIT_VALUE;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_rnd_data = data_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: three instances with STEPS_PER_OUT = 1, 2 and 4.
// Expected words are derived by hand from INIT_VALUE 0xAAAA and taps 15,13,12,10.
module tb_lfsr_prng;

  logic        clk;
  logic        rst;
  logic        en1, load1, ready1;
  logic [15:0] seed1;
  logic [15:0] data1;
  logic        v1, lk1;
  logic        en2;
  logic [15:0] data2, data4;
  logic        v2, lk2, v4, lk4;

  int total;
  int bad;

`ifdef LFSR_PRNG_ZERO_GUARD_EN
  localparam logic        ExpLockup   = 1'b1;
  localparam logic [15:0] ExpZeroWord = 16'h5554;
`else
  localparam logic        ExpLockup   = 1'b0;
  localparam logic [15:0] ExpZeroWord = 16'h0000;
`endif

  lfsr_prng #(.STEPS_PER_OUT(1)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_en(en1), .in_load(load1), .in_seed(seed1),
    .in_ready(ready1), .out_rnd_data(data1), .out_valid(v1), .out_lockup(lk1)
  );

  lfsr_prng #(.STEPS_PER_OUT(2)) dut2 (
    .in_clk(clk), .in_rst(rst), .in_en(en2), .in_load(1'b0), .in_seed(16'h0000),
    .in_ready(1'b1), .out_rnd_data(data2), .out_valid(v2), .out_lockup(lk2)
  );

  lfsr_prng #(.STEPS_PER_OUT(4)) dut4 (
    .in_clk(clk), .in_rst(rst), .in_en(en2), .in_load(1'b0), .in_seed(16'h0000),
    .in_ready(1'b1), .out_rnd_data(data4), .out_valid(v4), .out_lockup(lk4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    en1    = 1'b0;
    load1  = 1'b0;
    ready1 = 1'b0;
    seed1  = 16'h0000;
    en2    = 1'b0;

    // Reset values, before any clock edge
    #3;
    check("rst_data1", data1, 16'h0000);
    check("rst_valid1", v1, 1'b0);
    check("rst_lockup1", lk1, 1'b0);
    check("rst_valid4", v4, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_valid1", v1, 1'b0);

    // STEPS_PER_OUT = 2 and 4, consumer always ready
    en2 = 1'b1;
    tick();
    check("s2_k_valid", v2, 1'b0);
    tick();
    check("s2_k1_valid", v2, 1'b0);
    tick();
    check("s2_k2_valid", v2, 1'b1);
    check("s2_word0", data2, 16'hAAA8);
    tick();
    check("s2_k3_valid", v2, 1'b0);
    check("s4_k3_valid", v4, 1'b0);
    tick();
    check("s4_k4_valid", v4, 1'b1);
    check("s4_word0", data4, 16'hAAA0);
    check("s2_k4_valid", v2, 1'b0);
    en2 = 1'b0;
    tick();
    check("s2_k5_valid", v2, 1'b1);
    check("s2_word1", data2, 16'hAAA0);
    check("s4_k5_valid", v4, 1'b0);
    tick();
    check("s2_k6_valid", v2, 1'b0);

    // STEPS_PER_OUT = 1 streaming
    en1    = 1'b1;
    ready1 = 1'b1;
    tick();
    check("s1_k_valid", v1, 1'b0);
    tick();
    check("s1_w0_valid", v1, 1'b1);
    check("s1_w0", data1, 16'h5554);
    tick();
    check("s1_hs0_valid", v1, 1'b0);
    tick();
    check("s1_w1_valid", v1, 1'b1);
    check("s1_w1", data1, 16'hAAA8);
    tick();
    check("s1_hs1_valid", v1, 1'b0);
    tick();
    check("s1_w2_valid", v1, 1'b1);
    check("s1_w2", data1, 16'h5550);

    // Backpressure: word and valid must hold
    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", v1, 1'b1);
      check("bp_data", data1, 16'h5550);
    end
    ready1 = 1'b1;
    tick();
    check("bp_hs_valid", v1, 1'b0);
    tick();
    check("bp_next_valid", v1, 1'b1);
    check("bp_next", data1, 16'hAAA0);

    // Seed load while a word is pending and ready is high: word discarded
    load1 = 1'b1;
    seed1 = 16'h0001;
    tick();
    check("ld_valid", v1, 1'b0);
    check("ld_data_kept", data1, 16'hAAA0);
    load1 = 1'b0;
    en1   = 1'b0;
    tick();
    check("ld_idle_valid", v1, 1'b0);
    en1 = 1'b1;
    tick();
    check("ld_k_valid", v1, 1'b0);
    tick();
    check("ld_w0_valid", v1, 1'b1);
    check("ld_w0", data1, 16'h0002);
    tick();
    check("ld_hs_valid", v1, 1'b0);
    tick();
    check("ld_w1_valid", v1, 1'b1);
    check("ld_w1", data1, 16'h0004);
    en1 = 1'b0;
    tick();
    check("ld_end_valid", v1, 1'b0);
    tick();
    check("ld_stay_idle", v1, 1'b0);

    // Zero seed
    load1 = 1'b1;
    seed1 = 16'h0000;
    tick();
    check("z_lockup", lk1, ExpLockup);
    check("z_valid", v1, 1'b0);
    load1 = 1'b0;
    en1   = 1'b1;
    tick();
    check("z_lockup_end", lk1, 1'b0);
    check("z_k_valid", v1, 1'b0);
    tick();
    check("z_w_valid", v1, 1'b1);
    check("z_word", data1, ExpZeroWord);
    en1 = 1'b0;

    // Async reset in the middle of STEP (STEPS_PER_OUT = 4)
    en2 = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid4", v4, 1'b0);
    check("ar_data4", data4, 16'h0000);
    check("ar_data2", data2, 16'h0000);
    check("ar_data1", data1, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("ar_s2_valid", v2, 1'b1);
    check("ar_s2_word", data2, 16'hAAA8);
    tick();
    check("ar_s4_early", v4, 1'b0);
    tick();
    check("ar_s4_valid", v4, 1'b1);
    check("ar_s4_word", data4, 16'hAAA0);
    check("ar_lk_quiet", lk2 | lk4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
